// File: rtl/mux8_sched_pkg.sv
// rtl/mux8_sched_pkg.sv - shared state encodings and default sizes for the round-robin lane scheduler
package mux8_sched_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int N_REQ_DEF  = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// rtl/mux8_rr_scheduler_if.sv - requester lanes plus downstream valid/ready bus of the lane scheduler
interface mux8_rr_scheduler_if
  import mux8_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    input  req, din, out_ready,
    output ack, out_data, out_sel, out_valid, busy
  );

  modport slave (
    output req, din, out_ready,
    input  ack, out_data, out_sel, out_valid, busy
  );

endinterface

// File: rtl/mux8_rr_scheduler_rr_pick.sv
// rtl/mux8_rr_scheduler_rr_pick.sv - rotating priority encoder: first set req bit at or after ptr, wrapping
module rr_pick
  import mux8_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  int               idx;
  logic [SEL_W-1:0] cand;

  // Scan from the far end back towards ptr so the last hit is the highest priority.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx  = (int'(ptr) + i) % N_REQ;
      cand = idx[SEL_W-1:0];
      if (req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler over one 8:1 lane-select datapath with valid/ready output
// Optional lane bursting is enabled by defining MUX8_SCHED_BURST_EN.
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MUX8_SCHED_BURST_EN
  ,
  parameter int MAX_BURST = 4
`endif
) (
  input logic                 clk,
  input logic                 rst,
  mux8_rr_scheduler_if.master bus
);

  localparam int SEL_W = $clog2(N_REQ);

  logic              state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  pick;
  logic              pick_any;
  logic [SEL_W-1:0]  grant;
  logic              grant_any;
  logic [SEL_W-1:0]  next_ptr;
  logic [DATA_W-1:0] lane_word;
  logic              handshake;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (pick),
    .any    (pick_any)
  );

`ifdef MUX8_SCHED_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0] burst_cnt;
  logic               regrant;

  // out_sel still holds the last winner while IDLE; burst_cnt==0 means no grant yet.
  assign regrant   = (burst_cnt != '0) && (burst_cnt < BURST_W'(MAX_BURST)) && bus.req[bus.out_sel];
  assign grant     = regrant ? bus.out_sel : pick;
  assign grant_any = regrant | pick_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state == ST_IDLE && grant_any) begin
      if (regrant)
        burst_cnt <= burst_cnt + 1'b1;
      else
        burst_cnt <= BURST_W'(1);
    end
  end
`else
  assign grant     = pick;
  assign grant_any = pick_any;
`endif

  assign lane_word = bus.din[int'(grant)*DATA_W +: DATA_W];
  assign handshake = (state == ST_BUSY) && bus.out_valid && bus.out_ready;
  assign next_ptr  = (bus.out_sel == SEL_W'(N_REQ - 1)) ? '0 : bus.out_sel + 1'b1;
  assign bus.busy  = (state == ST_BUSY);

  always_comb begin
    bus.ack = '0;
    if (handshake && !rst)
      bus.ack[bus.out_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_any) begin
        bus.out_sel   <= grant;
        bus.out_data  <= lane_word;
        bus.out_valid <= 1'b1;
        state         <= ST_BUSY;
      end
    end else if (handshake) begin
      bus.out_valid <= 1'b0;
      ptr           <= next_ptr;
      state         <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb/tb_mux8_rr_scheduler.sv - scoreboard bench for the round-robin lane scheduler
module tb_mux8_rr_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux8_rr_scheduler_if #(.N_REQ(8), .DATA_W(8)) bus ();

  mux8_rr_scheduler #(.N_REQ(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [7:0] lane_val(int i);
    return 8'((i << 4) | (15 - i));
  endfunction

  task automatic set_lanes();
    for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = lane_val(i);
  endtask

  task automatic push_beat(int sel, logic [7:0] data);
    beat_t b;
    b.sel  = 3'(sel);
    b.data = data;
    sb_q.push_back(b);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    beat_t b;
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    set_lanes();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 8'h00 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b ack=%h busy=%b, required 0/00/0", bus.out_valid, bus.ack, bus.busy);
      end
    end
    rst = 1'b0;
    push_beat(0, lane_val(0));
    @(negedge clk);
    b = sb_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data || bus.ack !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_grant: valid=%b sel=%0d data=%h ack=%h, required 1/%0d/%h/01", bus.out_valid, bus.out_sel, bus.out_data, bus.ack, b.sel, b.data);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_back_idle: valid=%b busy=%b, required 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_single();
    beat_t b;
    bus.req = 8'h10;
    bus.din[4*8 +: 8] = 8'hA5;
    push_beat(4, 8'hA5);
    @(negedge clk);
    b = sb_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data || bus.ack !== 8'h10) begin
      errors++;
      $display("FAIL single: valid=%b sel=%0d data=%h ack=%h, required 1/%0d/%h/10", bus.out_valid, bus.out_sel, bus.out_data, bus.ack, b.sel, b.data);
    end
    bus.req = '0;
    set_lanes();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: valid=%b busy=%b, required 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_rotation();
    beat_t b;
    int    cyc;
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
`ifdef MUX8_SCHED_BURST_EN
      push_beat(k / 4, lane_val(k / 4));
`else
      push_beat(k % 8, lane_val(k % 8));
`endif
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      wait_valid(cyc);
      b = sb_q.pop_front();
      checks++;
      if (cyc != 0 || bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data || bus.ack !== (8'h01 << b.sel)) begin
        errors++;
        $display("FAIL rotation_beat%0d: late=%0d valid=%b sel=%0d data=%h ack=%h, required 0/1/%0d/%h/%h", k, cyc, bus.out_valid, bus.out_sel, bus.out_data, bus.ack, b.sel, b.data, 8'h01 << b.sel);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap%0d: valid=%b, required 0", k, bus.out_valid);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_backpressure();
    beat_t b;
    int    cyc;
    pulse_reset();
    bus.out_ready = 1'b0;
    bus.req = 8'h04;
    bus.din[2*8 +: 8] = 8'h22;
    push_beat(2, 8'h22);
    @(negedge clk);
    wait_valid(cyc);
    b = sb_q.pop_front();
    checks++;
    if (cyc != 0 || bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data) begin
      errors++;
      $display("FAIL bp_grant: late=%0d valid=%b sel=%0d data=%h, required 0/1/%0d/%h", cyc, bus.out_valid, bus.out_sel, bus.out_data, b.sel, b.data);
    end
    repeat (5) begin
      bus.din[2*8 +: 8] = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd2 || bus.out_data !== 8'h22 || bus.ack !== 8'h00) begin
        errors++;
        $display("FAIL bp_hold: valid=%b sel=%0d data=%h ack=%h, required 1/2/22/00", bus.out_valid, bus.out_sel, bus.out_data, bus.ack);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 8'h04) begin
      errors++;
      $display("FAIL bp_ack: ack=%h, required 04", bus.ack);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b busy=%b, required 0/0", bus.out_valid, bus.busy);
    end
    set_lanes();
  endtask

  task automatic test_mid_reset();
    beat_t b;
    int    cyc;
    pulse_reset();
    bus.out_ready = 1'b0;
    bus.req = 8'h08;
    push_beat(3, lane_val(3));
    @(negedge clk);
    wait_valid(cyc);
    b = sb_q.pop_front();
    checks++;
    if (cyc != 0 || bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data) begin
      errors++;
      $display("FAIL midrst_grant: late=%0d valid=%b sel=%0d data=%h, required 0/1/%0d/%h", cyc, bus.out_valid, bus.out_sel, bus.out_data, b.sel, b.data);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.req = 8'h81;
    #1;
    checks++;
    if (bus.ack !== 8'h00) begin
      errors++;
      $display("FAIL midrst_no_ack: ack=%h, required 00", bus.ack);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 8'h00) begin
      errors++;
      $display("FAIL midrst_dropped: valid=%b busy=%b ack=%h, required 0/0/00", bus.out_valid, bus.busy, bus.ack);
    end
    rst = 1'b0;
    push_beat(0, lane_val(0));
    @(negedge clk);
    wait_valid(cyc);
    b = sb_q.pop_front();
    checks++;
    if (cyc != 0 || bus.out_sel !== b.sel || bus.out_data !== b.data || bus.ack !== 8'h01) begin
      errors++;
      $display("FAIL midrst_ptr0: late=%0d sel=%0d data=%h ack=%h, required 0/%0d/%h/01", cyc, bus.out_sel, bus.out_data, bus.ack, b.sel, b.data);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    beat_t b;
    int    cyc;
`ifdef MUX8_SCHED_BURST_EN
    int    lanes[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int    n = 9;
`else
    int    lanes[9] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    int    n = 4;
`endif
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.req = 8'h03;
    for (int k = 0; k < n; k++) push_beat(lanes[k], lane_val(lanes[k]));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wait_valid(cyc);
      b = sb_q.pop_front();
      checks++;
      if (cyc != 0 || bus.out_valid !== 1'b1 || bus.out_sel !== b.sel || bus.out_data !== b.data) begin
        errors++;
        $display("FAIL burst_beat%0d: late=%0d valid=%b sel=%0d data=%h, required 0/1/%0d/%h", k, cyc, bus.out_valid, bus.out_sel, bus.out_data, b.sel, b.data);
      end
      @(negedge clk);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_mid_reset();
    test_burst();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d beats left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
